plic_gateway: RTL
=================

PLIC_GATEWAY -- requirements
Module: plic_gateway

Interface
REQ-001 Parameter: SOURCES, default 8, number of interrupt sources (IDs 1..SOURCES; ID 0 = none).
REQ-002 Parameter: SOURCES_BITS, default 4, ID width; SHALL satisfy 2**SOURCES_BITS > SOURCES.
REQ-003 Parameter: TARGETS, default 1, number of interrupt targets.
REQ-004 Parameter: MAX_PENDING_CNT, default 8, saturation value of the per-source edge counter.
REQ-005 Clocking (already decided): one clock; reset is asynchronous and active-low.
REQ-006 Port: clk  input  1  sole clock.
REQ-007 Port: rstn  input  1  asynchronous active-low reset.
REQ-008 Port: src  input  SOURCES  raw asynchronous interrupt lines; bit k-1 is ID k.
REQ-009 Port: el  input  SOURCES  per-source mode; 1 = edge-sensitive, 0 = level-sensitive.
REQ-010 Port: claim  input  TARGETS  one-cycle claim strobe per target.
REQ-011 Port: complete  input  TARGETS  one-cycle complete strobe per target.
REQ-012 Port: id  input  SOURCES_BITS x TARGETS (unpacked [TARGETS])  ID being claimed or completed per target.
REQ-013 Port: ip  output  SOURCES  registered interrupt-pending vector, consumed by the register file.

Function
REQ-014 src SHALL pass through a 2-flop synchronizer (s1, s2); all logic uses s2 and its one-cycle-delayed copy s3.
REQ-015 Edge event for source k SHALL be s2[k] & ~s3[k], counted only when el[k]=1.
REQ-016 Each source SHALL run an FSM with states IDLE, PEND, CLAIMED; ip[k]=1 only in PEND.
REQ-017 Level mode: IDLE->PEND when s2[k]=1; PEND->CLAIMED on claim; CLAIMED->IDLE on complete.
REQ-018 Edge mode: IDLE->PEND on an edge event or when cnt[k]!=0; PEND->CLAIMED on claim; CLAIMED->IDLE on complete.
REQ-019 Edge mode, edge event while not IDLE: cnt[k] += 1, saturating at MAX_PENDING_CNT.
REQ-020 Edge mode, IDLE with cnt[k]!=0 and no edge event: enter PEND and decrement cnt[k]; with both present: enter PEND, cnt[k] unchanged.
REQ-021 A claim matches source k when claim[t]=1 and id[t]==k for any target t; complete matches likewise.
REQ-022 A claim in IDLE or CLAIMED, and a complete in IDLE or PEND, SHALL be ignored.
REQ-023 A matching claim and complete on the same cycle SHALL act per current state only: PEND->CLAIMED; CLAIMED->IDLE.
REQ-024 id==0 or id>SOURCES SHALL be ignored.
REQ-025 When el[k]=0, cnt[k] SHALL be held at 0; an el change takes effect on the next state decision.
REQ-026 Latency: src rising before clock edge n SHALL give ip=1 after edge n+2 (3 edges); complete at edge m SHALL drop the source to IDLE at m, with a level re-pend at m+1 if s2 is still high.
REQ-027 The counter SHALL be ceil(log2(MAX_PENDING_CNT+1)) bits; no wrap-around.

Reset
REQ-028 On rstn=0, asynchronously: s1, s2, s3 = 0; all FSMs = IDLE; all cnt = 0; ip = 0.
REQ-029 A reset mid-operation SHALL discard pending, claimed and counted events; no edge is detected on the first cycle after release.

Structure
REQ-030 Package plic_pkg SHALL hold the state enum (IDLE/PEND/CLAIMED) and the MAX_PENDING_CNT default.
REQ-031 The per-source FSM plus counter SHALL be sub-module plic_gateway_cell, instantiated SOURCES times in a generate loop; synchronizer and claim/complete decode stay at top level.

Verification
REQ-032 Level: src[2]=1 held -> ip[2]=1 three edges later; claim id=3 -> ip[2]=0 next cycle; complete id=3 with src high -> ip[2]=1 again two edges later.
REQ-033 Edge: 3 pulses on src[0] (el[0]=1) while CLAIMED -> cnt=3; three claim/complete rounds with id=1 -> ip[0] re-asserts each time, then stays 0.
REQ-034 Saturation: 12 pulses on src[1] (el=1) while CLAIMED -> cnt=8; exactly 8 further PEND episodes follow.
REQ-035 Same-cycle claim and complete id=5 in PEND -> state CLAIMED, ip[4]=0; stray complete id=5 in IDLE -> no change.
REQ-036 Reset: rstn low while sources are PEND/CLAIMED with cnt=4 -> ip=0 immediately; after release with src low, ip stays 0.

Source files
------------

// File: rtl/plic_pkg.sv
// rtl/plic_pkg.sv - shared types and defaults for the PLIC interrupt gateway
//
// Purpose: holds the per-source gateway state encoding, the default
// saturation value of the edge counter and the counter-width helper.
// Ports: none (package).

package plic_pkg;

  // Default saturation value of the per-source edge counter.
  localparam int PLIC_MAX_PENDING_CNT = 8;

  // Per-source gateway state.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    CLAIMED = 2'd2
  } gw_state_e;

  // Bits needed to hold 0..max_cnt without wrap-around.
  function automatic int cnt_width(input int max_cnt);
    return (max_cnt < 1) ? 1 : $clog2(max_cnt + 1);
  endfunction

endpackage

// File: rtl/plic_gateway_cell.sv
// rtl/plic_gateway_cell.sv - per-source gateway FSM with saturating edge counter
//
// Purpose: tracks one interrupt source through IDLE -> PEND -> CLAIMED -> IDLE.
// Level sources pend while the synchronized line is high; edge sources pend
// on each edge and bank edges that arrive while busy in a saturating counter.
// Ports:
//   clk          in   clock
//   rstn         in   asynchronous active-low reset
//   el           in   1 = edge-sensitive, 0 = level-sensitive
//   level        in   synchronized source line (s2)
//   edge_evt     in   rising edge of the synchronized line (s2 & ~s3)
//   claim_hit    in   some target claimed this source this cycle
//   complete_hit in   some target completed this source this cycle
//   ip           out  1 while the source is in PEND

module plic_gateway_cell
  import plic_pkg::*;
#(
  parameter int MAX_PENDING_CNT = PLIC_MAX_PENDING_CNT
) (
  input  logic clk,
  input  logic rstn,
  input  logic el,
  input  logic level,
  input  logic edge_evt,
  input  logic claim_hit,
  input  logic complete_hit,
  output logic ip
);

  localparam int CW = cnt_width(MAX_PENDING_CNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PENDING_CNT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  gw_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            edge_hit;

  // Edges only count for sources configured as edge-sensitive.
  assign edge_hit = el & edge_evt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (el) begin
          // A fresh edge is served directly; banked edges are drawn down
          // only when no new edge arrives in the same cycle.
          if (edge_hit) begin
            state_d = PEND;
          end else if (cnt_q != '0) begin
            state_d = PEND;
            cnt_d   = cnt_q - CNT_ONE;
          end
        end else if (level) begin
          state_d = PEND;
        end
      end
      PEND: begin
        if (edge_hit && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_ONE;
        if (claim_hit) state_d = CLAIMED;
      end
      CLAIMED: begin
        if (edge_hit && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_ONE;
        if (complete_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Level sources never bank events.
    if (!el) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ip = (state_q == PEND);

endmodule

// File: rtl/plic_gateway.sv
// rtl/plic_gateway.sv - PLIC interrupt gateway: synchronizer, claim decode, per-source cells
//
// Purpose: synchronizes raw interrupt lines, decodes per-target claim and
// complete strobes into per-source hits and runs one gateway cell per source.
// Ports:
//   clk       in   sole clock
//   rstn      in   asynchronous active-low reset
//   src       in   raw asynchronous interrupt lines, bit k-1 is ID k
//   el        in   per-source mode, 1 = edge, 0 = level
//   claim     in   one-cycle claim strobe per target
//   complete  in   one-cycle complete strobe per target
//   id        in   ID claimed/completed per target (0 = none)
//   ip        out  interrupt-pending vector, bit k-1 is ID k

module plic_gateway
  import plic_pkg::*;
#(
  parameter int SOURCES         = 8,
  parameter int SOURCES_BITS    = 4,
  parameter int TARGETS         = 1,
  parameter int MAX_PENDING_CNT = PLIC_MAX_PENDING_CNT
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [SOURCES-1:0]      src,
  input  logic [SOURCES-1:0]      el,
  input  logic [TARGETS-1:0]      claim,
  input  logic [TARGETS-1:0]      complete,
  input  logic [SOURCES_BITS-1:0] id [TARGETS],
  output logic [SOURCES-1:0]      ip
);

  logic [SOURCES-1:0] s1_q, s1_d;
  logic [SOURCES-1:0] s2_q, s2_d;
  logic [SOURCES-1:0] s3_q, s3_d;
  logic [SOURCES-1:0] edge_evt;
  logic [SOURCES-1:0] claim_hit;
  logic [SOURCES-1:0] complete_hit;

  // s1/s2 form the synchronizer; s3 is a delayed s2 for edge detection.
  always_comb begin
    s1_d = src;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign edge_evt = s2_q & ~s3_q;

  // Source index k carries ID k+1, so ID 0 and IDs above SOURCES never match.
  always_comb begin
    claim_hit    = '0;
    complete_hit = '0;
    for (int k = 0; k < SOURCES; k++) begin
      for (int t = 0; t < TARGETS; t++) begin
        if (id[t] == SOURCES_BITS'(k + 1)) begin
          if (claim[t])    claim_hit[k]    = 1'b1;
          if (complete[t]) complete_hit[k] = 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < SOURCES; k++) begin : g_cell
    plic_gateway_cell #(
      .MAX_PENDING_CNT(MAX_PENDING_CNT)
    ) u_cell (
      .clk         (clk),
      .rstn        (rstn),
      .el          (el[k]),
      .level       (s2_q[k]),
      .edge_evt    (edge_evt[k]),
      .claim_hit   (claim_hit[k]),
      .complete_hit(complete_hit[k]),
      .ip          (ip[k])
    );
  end

endmodule
